// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit : multi-cycle RV32M multiply/divide unit, one bit per cycle.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle multiplier.  Rev 1.0
// ============================================================================
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kill,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3_q;
  logic              neg_q;
  logic              sa_q;
  logic [XLEN-1:0]   m_q;
  logic [2*XLEN-1:0] acc;

  logic              is_div, a_signed, b_signed, sa, sb;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_res;

  assign is_div   = funct3[2];
  assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
  assign b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign sa       = a_signed & op_a[XLEN-1];
  assign sb       = b_signed & op_b[XLEN-1];
  assign a_mag    = sa ? -op_a : op_a;
  assign b_mag    = sb ? -op_b : op_b;
  assign div_zero = (op_b == '0);
  assign div_ovf  = ~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&op_b);
  assign special_res = div_zero ? (funct3[1] ? op_a : '1)
                                : (funct3[1] ? '0 : op_a);

  // acc holds {hi, lo} of the product, or {remainder, dividend/quotient}
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh, rem_diff;
  logic [2*XLEN-1:0] acc_nxt;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m_q} : '0);
  assign rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, m_q};

  always_comb begin
    acc_nxt = acc;
    if (!f3_q[2])
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
    else if (rem_diff[XLEN])
      acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      acc_nxt = {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, calc_res;

  assign prod_fix = neg_q ? -acc_nxt : acc_nxt;
  assign quo_fix  = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
  assign rem_fix  = sa_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];

  always_comb begin
    calc_res = '0;
    case (f3_q)
      3'b000:                 calc_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: calc_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         calc_res = quo_fix;
      default:                calc_res = rem_fix;
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fa, fb, fprod;
  logic [XLEN-1:0]          fast_res;

  assign fa       = {{XLEN{a_signed & op_a[XLEN-1]}}, op_a};
  assign fb       = {{XLEN{b_signed & op_b[XLEN-1]}}, op_b};
  assign fprod    = fa * fb;
  assign fast_res = (funct3[1:0] == 2'b00) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      f3_q   <= '0;
      neg_q  <= 1'b0;
      sa_q   <= 1'b0;
      m_q    <= '0;
      acc    <= '0;
      result <= '0;
      rd_out <= '0;
    end else if (kill) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            f3_q   <= funct3;
            rd_out <= rd_in;
            neg_q  <= sa ^ sb;
            sa_q   <= sa;
            cnt    <= '0;
            if (is_div && (div_zero || div_ovf)) begin
              result <= special_res;
              state  <= DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!is_div) begin
              result <= fast_res;
              state  <= DONE;
            end
`endif
            else begin
              m_q   <= is_div ? b_mag : a_mag;
              acc   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN - 1)) begin
            result <= calc_res;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            result <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// Directed-vector testbench for muldiv_unit (XLEN=32).
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        kill = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .kill(kill),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .rd_out(rd_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    @(negedge clk);
    funct3 = f3; op_a = a; op_b = b; rd_in = rd; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge (inclusive) until out_valid is seen.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat);
    int cyc;
    start_op(f3, a, b, rd);
    wait_valid(cyc);
    check({tag, " latency"}, 32'(cyc), 32'(lat));
    check({tag, " result"}, result, exp);
    check({tag, " rd_out"}, 32'(rd_out), 32'(rd));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " in_ready after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int cyc;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset result", result, 32'd0);
    check("reset rd_out", 32'(rd_out), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle in_ready", 32'(in_ready), 32'd1);

    run_op("MUL 7*-3",        3'b000, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, MUL_LAT);
    run_op("MULH min*min",    3'b001, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, MUL_LAT);
    run_op("MULHU max*max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, MUL_LAT);
    run_op("MULHSU -1*max",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, MUL_LAT);
    run_op("DIV -7/2",        3'b100, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, DIV_LAT);
    run_op("REM -7/2",        3'b110, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, DIV_LAT);
    run_op("DIV 7/-2",        3'b100, 32'd7,        32'hFFFFFFFE, 5'd7,  32'hFFFFFFFD, DIV_LAT);
    run_op("REM 7/-2",        3'b110, 32'd7,        32'hFFFFFFFE, 5'd8,  32'd1,        DIV_LAT);
    run_op("DIVU 100/7",      3'b101, 32'd100,      32'd7,        5'd9,  32'd14,       DIV_LAT);
    run_op("REMU 100/7",      3'b111, 32'd100,      32'd7,        5'd10, 32'd2,        DIV_LAT);
    run_op("DIVU 5/0",        3'b101, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 1);
    run_op("REM 5/0",         3'b110, 32'd5,        32'd0,        5'd12, 32'd5,        1);
    run_op("REMU 5/0",        3'b111, 32'd5,        32'd0,        5'd13, 32'd5,        1);
    run_op("DIV ovf",         3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1);
    run_op("REM ovf",         3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,        1);

    // Held result under back-pressure, with a competing request present.
    start_op(3'b101, 32'd100, 32'd7, 5'd20);
    wait_valid(cyc);
    check("hold latency", 32'(cyc), 32'(DIV_LAT));
    @(negedge clk);
    funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4; rd_in = 5'd21; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold result", result, 32'd14);
      check("hold rd_out", 32'(rd_out), 32'd20);
      check("hold out_valid", 32'(out_valid), 32'd1);
      check("hold in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release in_ready", 32'(in_ready), 32'd1);
    check("release out_valid", 32'(out_valid), 32'd0);
    check("release result", result, 32'd0);

    // Kill mid-calculation with a new request pending.
    start_op(3'b101, 32'd100, 32'd7, 5'd22);
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1; in_valid = 1'b1;
    funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4; rd_in = 5'd23;
    @(posedge clk); #1;
    kill = 1'b0; in_valid = 1'b0;
    check("kill busy", 32'(busy), 32'd0);
    check("kill out_valid", 32'(out_valid), 32'd0);
    check("kill in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("kill not taken", 32'(busy), 32'd0);
    run_op("DIVU after kill", 3'b101, 32'd100, 32'd7, 5'd24, 32'd14, DIV_LAT);

    // Asynchronous reset in the middle of a divide.
    start_op(3'b100, 32'hFFFFFFF9, 32'd2, 5'd25);
    repeat (5) @(posedge clk);
    #3;
    check("pre-reset busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async busy", 32'(busy), 32'd0);
    check("async out_valid", 32'(out_valid), 32'd0);
    check("async result", result, 32'd0);

    // Asynchronous reset while a result is held.
    @(negedge clk) rst_n = 1'b1;
    start_op(3'b101, 32'd5, 32'd0, 5'd26);
    check("done before reset", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async done out_valid", 32'(out_valid), 32'd0);
    check("async done result", result, 32'd0);
    check("async done rd_out", 32'(rd_out), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset in_ready", 32'(in_ready), 32'd1);
    run_op("MUL 3*4", 3'b000, 32'd3, 32'd4, 5'd27, 32'd12, MUL_LAT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
